// File: rtl/ucsbece152a_count_ctrl_if.sv
// Control bundle between the count controller and its environment.
// The slave side is the controller; the master side drives requests and count.
interface ucsbece152a_count_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start_i;
  logic             stop_i;
  logic             step_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] count_i;
  logic             enable_o;
  logic             dir_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, stop_i, step_i, mode_i, count_i,
    input  enable_o, dir_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stop_i, step_i, mode_i, count_i,
    output enable_o, dir_o, busy_o, done_o
  );
endinterface

// File: rtl/ucsbece152a_count_ctrl.sv
// Sequencing controller for the lab up/down counter: prescaled run,
// single step, ping-pong sweep and one-shot count-to-max.
module ucsbece152a_count_ctrl #(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input  logic clk,
  input  logic rst,
  ucsbece152a_count_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] PRE = MAX - ONE;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [1:0]    mode_q;
  logic          dir_q;
  logic          done_q;
  logic          pulse;
  logic          at_max;
  logic          at_pre;
  logic          dir_d;

  assign pulse  = (state_q == RUN && div_q == LAST) || state_q == STEP;
  assign at_max = bus.count_i == MAX;
  assign at_pre = bus.count_i == PRE;

  // Turn around one step before an endpoint so neither end repeats.
  always_comb begin
    dir_d = dir_q;
    if (!dir_q && at_pre)
      dir_d = 1'b1;
    else if (dir_q && bus.count_i == ONE)
      dir_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      mode_q  <= 2'b00;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!bus.stop_i) begin
            if (bus.start_i) begin
              mode_q <= bus.mode_i;
              if (bus.mode_i == 2'b10)
                dir_q <= at_max;
              // One-shot already at the top: finish without enabling.
              if (bus.mode_i == 2'b11 && at_max) begin
                done_q <= 1'b1;
              end else begin
                state_q <= RUN;
                div_q   <= '0;
              end
            end else if (bus.step_i) begin
              mode_q  <= bus.mode_i;
              state_q <= STEP;
              if (bus.mode_i == 2'b10)
                dir_q <= at_max;
            end
          end
        end
        RUN: begin
          div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
          if (bus.stop_i)
            state_q <= IDLE;
          if (pulse && mode_q == 2'b10)
            dir_q <= dir_d;
          if (pulse && mode_q == 2'b11 && at_pre) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        STEP: begin
          if (mode_q == 2'b10)
            dir_q <= dir_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.enable_o = pulse;
  assign bus.busy_o   = state_q == RUN;
  assign bus.done_o   = done_q;
  assign bus.dir_o    = (mode_q == 2'b01) | ((mode_q == 2'b10) & dir_q);
endmodule
